// File: rtl/dnn_feed_ctrl_if.sv
// Host and core signal bundle for dnn_feed_ctrl.
// master = controller side, slave = host/core environment side.
interface dnn_feed_ctrl_if;
    logic                load_valid;
    logic [4:0]          load_data;
    logic                load_ready;
    logic [19:0]         x_flat;
    logic [139:0]        w_flat;
    logic                in_ready;
    logic signed [16:0]  out0;
    logic signed [16:0]  out1;
    logic                out0_ready;
    logic                out1_ready;
    logic                res_valid;
    logic                res_ack;
    logic signed [16:0]  res0;
    logic signed [16:0]  res1;
    logic                res_err;
    logic                busy;

    modport master (
        input  load_valid, load_data,
        input  out0, out1, out0_ready, out1_ready,
        input  res_ack,
        output load_ready, x_flat, w_flat, in_ready,
        output res_valid, res0, res1, res_err, busy
    );

    modport slave (
        output load_valid, load_data,
        output out0, out1, out0_ready, out1_ready,
        output res_ack,
        input  load_ready, x_flat, w_flat, in_ready,
        input  res_valid, res0, res1, res_err, busy
    );
endinterface

// File: rtl/dnn_feed_ctrl.sv
// Host-side feeder for the dnn_opt_mult core: serial load, one-cycle
// launch, dual result capture with timeout, valid/ack return to host.
module dnn_feed_ctrl #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    dnn_feed_ctrl_if.master    bus
);
    typedef enum logic [1:0] {
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]   r_tcnt;
    logic [19:0]        r_x;
    logic [139:0]       r_w;
    logic signed [16:0] r_res0;
    logic signed [16:0] r_res1;
    logic               r_s0;
    logic               r_s1;
    logic               r_err;

    logic w_accept;
    logic w_last;
    logic w_run;
    logic w_cap0;
    logic w_cap1;
    logic w_both;
    logic w_tout;

    assign w_accept = (r_state == S_LOAD) && bus.load_valid;
    assign w_last   = w_accept && (r_wcnt == CNT_W'(31));
    assign w_run    = (r_state == S_FIRE) || (r_state == S_WAIT);
    assign w_cap0   = w_run && bus.out0_ready;
    assign w_cap1   = w_run && bus.out1_ready;
    assign w_both   = (r_s0 | w_cap0) & (r_s1 | w_cap1);
    // the counter value seen here is one behind the cycle being finished
    assign w_tout   = w_run && (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LOAD: if (w_last) w_next = S_FIRE;
            S_FIRE,
            S_WAIT: begin
                if (w_both || w_tout) w_next = S_DONE;
                else                  w_next = S_WAIT;
            end
            S_DONE: if (bus.res_ack) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
            r_tcnt <= '0;
            r_x    <= '0;
            r_w    <= '0;
            r_res0 <= '0;
            r_res1 <= '0;
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int k = 0; k < 4; k++)
                    if (r_wcnt == CNT_W'(k))
                        r_x[5*k +: 5] <= bus.load_data;
                for (int k = 0; k < 28; k++)
                    if (r_wcnt == CNT_W'(k + 4))
                        r_w[5*k +: 5] <= bus.load_data;
                r_wcnt <= w_last ? '0 : r_wcnt + 1'b1;
            end
            // a fresh launch wipes stale results so a timeout reads 0
            if (w_last) begin
                r_tcnt <= '0;
                r_s0   <= 1'b0;
                r_s1   <= 1'b0;
                r_res0 <= '0;
                r_res1 <= '0;
                r_err  <= 1'b0;
            end
            if (w_run) begin
                r_tcnt <= r_tcnt + 1'b1;
                if (w_cap0) begin
                    r_res0 <= bus.out0;
                    r_s0   <= 1'b1;
                end
                if (w_cap1) begin
                    r_res1 <= bus.out1;
                    r_s1   <= 1'b1;
                end
                if (!w_both && w_tout) r_err <= 1'b1;
            end
        end
    end

    assign bus.load_ready = (r_state == S_LOAD);
    assign bus.busy       = (r_state != S_LOAD);
    assign bus.in_ready   = (r_state == S_FIRE);
    assign bus.res_valid  = (r_state == S_DONE);
    assign bus.x_flat     = r_x;
    assign bus.w_flat     = r_w;
    assign bus.res0       = r_res0;
    assign bus.res1       = r_res1;
    assign bus.res_err    = r_err;
endmodule

// File: tb/tb_dnn_feed_ctrl.sv
// Bench for dnn_feed_ctrl: directed host/core stimulus, transaction-level
// model compared every cycle, plus literal checks on key results.
module tb_dnn_feed_ctrl;
    localparam int TO = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dnn_feed_ctrl_if bus();

    dnn_feed_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // transaction-level model: words seen, launch age, captured results
    logic [4:0]  m_words[32];
    int          m_cnt;
    bit          m_launch;
    bit          m_done;
    bit          m_got0;
    bit          m_got1;
    bit          m_err;
    int          m_age;
    logic [16:0] m_v0;
    logic [16:0] m_v1;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_words[i] = '0;
        m_cnt = 0; m_launch = 0; m_done = 0; m_age = 0;
        m_got0 = 0; m_got1 = 0; m_err = 0;
        m_v0 = '0; m_v1 = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else if (m_done) begin
                if (bus.res_ack) m_done = 0;
            end else if (m_launch) begin
                if (bus.out0_ready) begin m_got0 = 1; m_v0 = bus.out0; end
                if (bus.out1_ready) begin m_got1 = 1; m_v1 = bus.out1; end
                m_age++;
                if (m_got0 && m_got1) begin
                    m_launch = 0; m_done = 1; m_err = 0;
                end else if (m_age == TO) begin
                    m_launch = 0; m_done = 1; m_err = 1;
                end
            end else if (bus.load_valid) begin
                m_words[m_cnt] = bus.load_data;
                m_cnt++;
                if (m_cnt == 32) begin
                    m_cnt = 0; m_launch = 1; m_age = 0;
                    m_got0 = 0; m_got1 = 0; m_err = 0;
                    m_v0 = '0; m_v1 = '0;
                end
            end
        end
    end

    initial begin
        logic [19:0]  ex;
        logic [139:0] ew;
        bit           idle;
        forever begin
            @(negedge clk);
            idle = !m_launch && !m_done;
            for (int k = 0; k < 4; k++) ex[5*k +: 5] = m_words[k];
            for (int k = 0; k < 28; k++) ew[5*k +: 5] = m_words[4+k];
            chk("load_ready", bus.load_ready, idle);
            chk("busy", bus.busy, !idle);
            chk("in_ready", bus.in_ready, m_launch && m_age == 0);
            chk("res_valid", bus.res_valid, m_done);
            chk("res0", {bus.res0}, m_v0);
            chk("res1", {bus.res1}, m_v1);
            chk("res_err", bus.res_err, m_err);
            chk("x_flat", bus.x_flat, ex);
            chk("w_flat", bus.w_flat, ew);
        end
    end

    logic [4:0] ld[32];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_all();
        for (int i = 0; i < 32; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = ld[i];
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic run_core(input int d0, input logic [16:0] v0,
                            input int d1, input logic [16:0] v1,
                            output int lat);
        lat = 0;
        chk("fire_cycle", bus.in_ready, 1'b1);
        while (!bus.res_valid && lat < 80) begin
            bus.out0_ready = (lat == d0);
            bus.out0       = v0;
            bus.out1_ready = (lat == d1);
            bus.out1       = v1;
            tick();
            lat++;
        end
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        chk("res_valid_bound", bus.res_valid, 1'b1);
    endtask

    task automatic ack();
        bus.res_ack = 1'b1;
        tick();
        bus.res_ack = 1'b0;
    endtask

    task automatic set_test1();
        ld[0] = 5'd4; ld[1] = 5'd2; ld[2] = 5'd4; ld[3] = 5'd1;
        for (int k = 0; k < 28; k++) ld[4+k] = 5'((k * 5 + 3) % 32);
        ld[31] = 5'd6;
    endtask

    initial begin
        int lat;
        bus.load_valid = 0; bus.load_data = '0;
        bus.out0 = '0; bus.out1 = '0;
        bus.out0_ready = 0; bus.out1_ready = 0;
        bus.res_ack = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_load_ready", bus.load_ready, 1'b1);
        chk("rst_res_valid", bus.res_valid, 1'b0);

        bus.out0_ready = 1; bus.out0 = 17'h00123;
        bus.out1_ready = 1; bus.out1 = 17'h00456;
        bus.res_ack = 1;
        tick();
        bus.out0_ready = 0; bus.out1_ready = 0; bus.res_ack = 0;
        tick();
        chk("load_strobe_ignored", {bus.res0}, 17'h0);

        set_test1();
        load_all();
        chk("t1_x_flat", bus.x_flat, 20'h09044);
        chk("t1_w_slot0", bus.w_flat[4:0], 5'b00011);
        chk("t1_w_slot27", bus.w_flat[139:135], 5'b00110);
        run_core(3, 17'h1FD2A, 5, 17'h1FEA4, lat);
        chk("t1_latency", lat, 6);
        chk("t1_res0", {bus.res0}, 17'h1FD2A);
        chk("t1_res1", {bus.res1}, 17'h1FEA4);
        chk("t1_err", bus.res_err, 1'b0);
        bus.out0_ready = 1; bus.out0 = 17'h00555;
        tick();
        bus.out0_ready = 0;
        repeat (2) tick();
        chk("t1_hold_valid", bus.res_valid, 1'b1);
        chk("t1_hold_res0", {bus.res0}, 17'h1FD2A);
        ack();
        chk("t1_ack_ready", bus.load_ready, 1'b1);

        load_all();
        run_core(2, 17'h10000, 2, 17'h10000, lat);
        chk("t2_latency", lat, 3);
        chk("t2_res0", {bus.res0}, 17'h10000);
        chk("t2_res1", {bus.res1}, 17'h10000);
        ack();

        for (int i = 0; i < 32; i++) ld[i] = 5'h0F;
        load_all();
        chk("t3_x_flat", bus.x_flat, 20'h7BDEF);
        run_core(1, 17'd54000, 4, 17'd54000, lat);
        chk("t3_res0", {bus.res0}, 17'd54000);
        chk("t3_res1", {bus.res1}, 17'd54000);
        ack();

        set_test1();
        load_all();
        run_core(2, 17'd1173, -1, 17'h0, lat);
        chk("to_latency", lat, 32);
        chk("to_res0", {bus.res0}, 17'd1173);
        chk("to_res1", {bus.res1}, 17'd0);
        chk("to_err", bus.res_err, 1'b1);
        ack();

        for (int i = 0; i < 20; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = ld[i];
            tick();
            if (i == 10) begin
                bus.load_valid = 1'b0;
                repeat (5) tick();
            end
        end
        bus.load_valid = 1'b1;
        bus.load_data  = ld[20];
        #1 rst_n = 1'b0;
        #1;
        chk("rst_x_zero", bus.x_flat, 20'h0);
        chk("rst_w_zero", bus.w_flat, 140'h0);
        chk("rst_ready", bus.load_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.load_valid = 1'b0;
        tick();
        load_all();
        chk("rl_x_flat", bus.x_flat, 20'h09044);
        chk("rl_w_slot0", bus.w_flat[4:0], 5'b00011);
        run_core(3, 17'h1FD2A, 5, 17'h1FEA4, lat);
        chk("rl_latency", lat, 6);
        ack();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
